mem_block_mover: RTL and testbench
==================================

Name: mem_block_mover

Overview:
- Bus initiator that drives the single-port data memory interface: address, write data, read strobe, write strobe, read data.
- Performs block copy (memory-to-memory) or block fill (constant-to-memory) of N 32-bit words, word-addressed.
- Sits beside the datapath as a memory-side engine. Software-visible control: start/busy/done/error.
- Memory contract: read is combinational (read data valid in the same cycle as address+read); write commits on the rising clk edge while write is high.

Parameters:
- MEM_DEPTH, 2010, number of addressable words in the target memory; legal addresses are 0..MEM_DEPTH-1.
- LEN_W, 16, width of the length and progress counters.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill.
- src_addr  input  32  first source word address (copy only).
- dst_addr  input  32  first destination word address.
- length  input  LEN_W  number of words.
- fill_data  input  32  fill value (fill only).
- busy  output  1  high in READ/WRITE states.
- done  output  1  one-cycle completion pulse.
- error  output  1  range error flag for the last request.
- words_done  output  LEN_W  words written so far in the current/last request.
- mem_address  output  32  memory address.
- mem_write_data  output  32  memory write data.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_read_data  input  32  memory read data, combinational.

Behaviour:
- Reset (rst high at posedge): state=IDLE; busy=0, done=0, error=0, words_done=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0; internal regs cleared. rst overrides everything, including mid-transfer: the transfer is abandoned, no further writes occur, and no done pulse is produced.
- States: IDLE, READ, WRITE, DONE.
- IDLE, start=1 at posedge:
  - Latch all request inputs.
  - Clear error and words_done.
  - Range check in 33-bit arithmetic: error_cond = (length!=0) && ((dst_addr+length > MEM_DEPTH) || (mode==0 && src_addr+length > MEM_DEPTH)).
  - error_cond -> DONE with error=1; no memory access.
  - length==0 -> DONE with error=0.
  - Otherwise -> READ (copy) or WRITE (fill).
- READ (copy only):
  - mem_read=1, mem_address=src_addr+words_done.
  - At posedge, capture mem_read_data into the data buffer and go to WRITE.
- WRITE:
  - mem_write=1, mem_address=dst_addr+words_done.
  - mem_write_data = buffer (copy) or fill_data latched (fill).
  - At posedge, words_done increments.
  - If words_done+1 == length -> DONE; else -> READ (copy) or stay in WRITE (fill).
- DONE: done=1 for exactly one cycle, then IDLE. error and words_done hold until the next accepted start.
- Strobes: mem_read and mem_write are never high together. Both are 0 outside READ/WRITE. mem_address and mem_write_data are don't-care when their strobes are low.
- Throughput:
  - Copy: 2 cycles/word.
  - Fill: 1 cycle/word.
  - Copy of N words: done is high in the (2N+1)th cycle after the start edge. Fill: the (N+1)th.
- start while not IDLE: ignored. Request inputs are not re-sampled mid-transfer.
- Overlap: copy is strictly ascending, word at a time. With dst_addr>src_addr and overlapping ranges, already-written words are re-read (forward-propagation semantics); this is defined and must be reproduced by the model.
- Address arithmetic: 32-bit, never wraps because the range check precedes any access. length=2^LEN_W-1 is legal if in range.

Test Plan:
- Copy: memory[10..13]={1,2,3,4}, start mode=0 src=10 dst=100 length=4 -> 8 busy cycles, alternating read@10/write@100 ...; memory[100..103]={1,2,3,4}; done pulse in cycle 9; words_done=4; error=0.
- Fill: start mode=1 dst=2000 length=10 fill_data=0xDEADBEEF -> 10 consecutive write cycles to 2000..2009, no mem_read; done in cycle 11.
- Range/zero-length:
  - dst=2005 length=6 -> done next cycle, error=1, no strobes, memory unchanged.
  - length=0 -> done next cycle, error=0.
  - src=0 length=2010 dst=0 copy -> accepted, error=0.
- Overlap: memory[0..3]={7,8,9,5}, copy src=0 dst=1 length=3 -> memory[0..3]={7,7,7,7}.
- Reset mid-copy: rst asserted after the 2nd write of a 5-word copy -> next cycle all outputs 0, state IDLE, only 2 destination words modified, no done pulse.
- start held high while busy -> ignored. A new start the cycle after done -> accepted; error/words_done cleared.

Source files
------------

// File: rtl/mem_block_mover.sv
// mem_block_mover: memory-side block copy / block fill engine.
//
// Drives a single-port word-addressed data memory whose read data is combinational and whose
// writes commit on the rising clock edge. A request accepted in IDLE either copies length words
// from src_addr to dst_addr, one read then one write per word, or fills length words at dst_addr
// with fill_data, one write per cycle.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   start, mode              request pulse (sampled in IDLE only); 0 = copy, 1 = fill
//   src_addr, dst_addr       first source / destination word address
//   length, fill_data        number of words; fill value
//   busy, done, error        transfer in progress; one-cycle completion; range error
//   words_done               words written in the current / last request
//   mem_address, mem_write_data, mem_read, mem_write, mem_read_data   memory interface
module mem_block_mover #(
    parameter int unsigned MEM_DEPTH = 2010,
    parameter int unsigned LEN_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] length,
    input  logic [31:0]      fill_data,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_write_data,
    output logic             mem_read,
    output logic             mem_write,
    input  logic [31:0]      mem_read_data
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      fill_q, fill_d;
    logic [31:0]      buf_q, buf_d;
    logic [LEN_W-1:0] wd_q, wd_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;

    logic [32:0]      dst_end, src_end;
    logic             range_err;
    logic [LEN_W-1:0] wd_inc;
    logic [31:0]      wd_ext;

    // 33-bit sums so an address near 2^32 cannot wrap past the depth check.
    assign dst_end   = {1'b0, dst_addr} + 33'(length);
    assign src_end   = {1'b0, src_addr} + 33'(length);
    assign range_err = (length != '0) &&
                       ((dst_end > 33'(MEM_DEPTH)) || (!mode && (src_end > 33'(MEM_DEPTH))));
    assign wd_inc    = wd_q + 1'b1;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        buf_d   = buf_q;
        wd_d    = wd_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = length;
                    fill_d = fill_data;
                    wd_d   = '0;
                    err_d  = range_err;
                    if (range_err || (length == '0)) begin
                        state_d = StDone;
                    end else begin
                        state_d = mode ? StWrite : StRead;
                    end
                end
            end
            StRead: begin
                buf_d   = mem_read_data;
                state_d = StWrite;
            end
            StWrite: begin
                wd_d = wd_inc;
                if (wd_inc == len_q) begin
                    state_d = StDone;
                end else begin
                    state_d = mode_q ? StWrite : StRead;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered: derive them from the state being entered.
        wd_ext  = 32'(wd_d);
        busy_d  = (state_d == StRead) || (state_d == StWrite);
        done_d  = (state_d == StDone);
        rd_d    = (state_d == StRead);
        wr_d    = (state_d == StWrite);
        addr_d  = '0;
        wdata_d = '0;
        if (state_d == StRead) begin
            addr_d = src_d + wd_ext;
        end else if (state_d == StWrite) begin
            addr_d  = dst_d + wd_ext;
            wdata_d = mode_d ? fill_d : buf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            buf_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            buf_q   <= buf_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = err_q;
    assign words_done     = wd_q;
    assign mem_read       = rd_q;
    assign mem_write      = wr_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// tb_mem_block_mover: directed self-checking bench for mem_block_mover.
// A behavioural memory serves the DUT; a reference copy of memory produces the expected write
// stream (address, data) into a scoreboard queue, which is popped as the DUT issues writes.
module tb_mem_block_mover;

    localparam int unsigned MEM_DEPTH = 2010;
    localparam int unsigned LEN_W     = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] length = '0;
    logic [31:0]      fill_data = '0;
    logic             busy, done, error;
    logic [LEN_W-1:0] words_done;
    logic [31:0]      mem_address, mem_write_data, mem_read_data;
    logic             mem_read, mem_write;

    logic [31:0] mem   [MEM_DEPTH];
    logic [31:0] model [MEM_DEPTH];
    logic [63:0] sb [$];

    int n_cmp = 0;
    int n_err = 0;
    int n_cyc, n_busy, n_done, n_rd, n_wr;

    mem_block_mover #(.MEM_DEPTH(MEM_DEPTH), .LEN_W(LEN_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .mode           (mode),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .length         (length),
        .fill_data      (fill_data),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .words_done     (words_done),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = (mem_address < MEM_DEPTH) ? mem[mem_address[10:0]] : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample just after the edge, retire any write the DUT is presenting.
    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        #1;
        n_cyc++;
        if (busy) n_busy++;
        if (done) n_done++;
        if (mem_read) n_rd++;
        chk("strobe_excl", {31'b0, mem_read & mem_write}, 32'd0);
        if (mem_write) begin
            n_wr++;
            e = (sb.size() != 0) ? sb.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
            chk("wr_addr", mem_address, e[63:32]);
            chk("wr_data", mem_write_data, e[31:0]);
            if (mem_address < MEM_DEPTH) mem[mem_address[10:0]] = mem_write_data;
        end
    endtask

    task automatic clr_counts();
        n_cyc = 0; n_busy = 0; n_done = 0; n_rd = 0; n_wr = 0;
    endtask

    task automatic setw(input int a, input logic [31:0] v);
        mem[a]   = v;
        model[a] = v;
    endtask

    // Issue one request and check timing, flags, strobes and the full write stream.
    task automatic run(input logic md, input int src, input int dst, input int len,
                       input logic [31:0] fd, input logic hold, input string tag);
        logic exp_err;
        int   exp_cyc, t;
        logic [31:0] d;
        exp_err = (len != 0) && ((longint'(dst) + len > MEM_DEPTH) ||
                                 (!md && (longint'(src) + len > MEM_DEPTH)));
        if (exp_err || len == 0) exp_cyc = 1;
        else exp_cyc = md ? len + 1 : 2 * len + 1;
        if (!exp_err) begin
            for (int i = 0; i < len; i++) begin
                d = md ? fd : model[src + i];
                model[dst + i] = d;
                sb.push_back({32'(dst + i), d});
            end
        end
        mode = md; src_addr = src; dst_addr = dst; length = LEN_W'(len); fill_data = fd;
        start = 1'b1;
        clr_counts();
        t = 0;
        while (t < 5000 && !done) begin
            tick();
            t++;
            if (!hold) start = 1'b0;
            else begin
                // Inputs must not be re-sampled while the request is in flight.
                src_addr = ~src_addr; dst_addr = ~dst_addr; fill_data = ~fill_data;
            end
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, 32'(t), 32'(exp_cyc));
        chk({tag, "_error"}, {31'b0, error}, {31'b0, exp_err});
        chk({tag, "_words_done"}, 32'(words_done), exp_err ? 32'd0 : 32'(len));
        chk({tag, "_busy_cycles"}, 32'(n_busy), 32'(exp_cyc - 1));
        chk({tag, "_reads"}, 32'(n_rd), (md || exp_err) ? 32'd0 : 32'(len));
        chk({tag, "_writes"}, 32'(n_wr), exp_err ? 32'd0 : 32'(len));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_err_hold"}, {31'b0, error}, {31'b0, exp_err});
    endtask

    initial begin
        logic [31:0] keep [5];
        for (int i = 0; i < MEM_DEPTH; i++) setw(i, $urandom);

        repeat (3) tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_words_done", 32'(words_done), 32'd0);
        chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        rst = 1'b0;
        tick();

        // Basic copy
        for (int i = 0; i < 4; i++) setw(10 + i, 32'(i + 1));
        run(1'b0, 10, 100, 4, 32'h0, 1'b0, "copy4");
        for (int i = 0; i < 4; i++) chk("copy4_mem", mem[100 + i], 32'(i + 1));

        // Fill with start held high and inputs toggled mid-transfer
        run(1'b1, 0, 2000, 10, 32'hDEAD_BEEF, 1'b1, "fill10");
        chk("fill10_last", mem[2009], 32'hDEAD_BEEF);

        // Range errors, then zero length (also shows error cleared on next start)
        keep[0] = mem[2005];
        run(1'b1, 0, 2005, 6, 32'h1234_5678, 1'b0, "rng_dst");
        chk("rng_dst_unchanged", mem[2005], keep[0]);
        run(1'b0, 2008, 0, 3, 32'h0, 1'b0, "rng_src");
        run(1'b0, 5, 6, 0, 32'h0, 1'b0, "zero_len");
        run(1'b1, 0, 2009, 1, 32'hA5A5_0001, 1'b0, "fill_edge");

        // Whole-memory copy is in range
        run(1'b0, 0, 0, 2010, 32'h0, 1'b0, "full_copy");

        // Overlapping forward copy propagates the first word
        setw(0, 32'd7); setw(1, 32'd8); setw(2, 32'd9); setw(3, 32'd5);
        run(1'b0, 0, 1, 3, 32'h0, 1'b0, "overlap");
        for (int i = 0; i < 4; i++) chk("overlap_mem", mem[i], 32'd7);

        // Reset during a 5-word copy, asserted once the 2nd write is on the bus
        for (int i = 0; i < 5; i++) keep[i] = mem[40 + i];
        for (int i = 0; i < 2; i++) begin
            model[40 + i] = model[20 + i];
            sb.push_back({32'(40 + i), model[20 + i]});
        end
        mode = 1'b0; src_addr = 20; dst_addr = 40; length = 5; start = 1'b1;
        clr_counts();
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("mrst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("mrst_words_done", 32'(words_done), 32'd0);
        chk("mrst_mem_address", mem_address, 32'd0);
        repeat (6) tick();
        chk("mrst_no_done", 32'(n_done), 32'd0);
        chk("mrst_writes", 32'(n_wr), 32'd2);
        chk("mrst_sb_empty", 32'(sb.size()), 32'd0);
        chk("mrst_w0", mem[40], model[20]);
        chk("mrst_w1", mem[41], model[21]);
        for (int i = 2; i < 5; i++) chk("mrst_untouched", mem[40 + i], keep[i]);

        // Engine is usable again, back-to-back requests
        run(1'b1, 0, 300, 3, 32'h0BAD_F00D, 1'b0, "post_rst_fill");
        run(1'b0, 300, 310, 3, 32'h0, 1'b0, "b2b_copy");
        for (int i = 0; i < 3; i++) chk("b2b_mem", mem[310 + i], 32'h0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
